pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard sequencer for the 16-bit, 5-stage pipelined CPU with its 4×16 register file. It tracks in-flight destination registers in a 3-entry scoreboard and stalls the IF/ID stages on read-after-write hazards. It flushes the three younger stages when a branch resolves taken in MEM and keeps saturating stall and flush event counters. It sits beside the CPU pipeline registers and drives their enables and bubble/flush controls; the datapath is otherwise unchanged.

## Interface
- `SB_DEPTH`, 3: scoreboard depth (EX, MEM, WB); fixed at 3 for this CPU.
- `CNT_W`, 16: width of the performance counters.
- `clock`  in  1  pipeline clock; all state changes on negedge, matching the CPU.
- `resetn`  in  1  reset, asynchronous and active-low.
- `hz_en`  in  1  1 = hazard checking active; 0 = stall never asserted (flush still active).
- `id_rs`, `id_rt`  in  2 each  source fields of the instruction in ID (`IFID_InstrReg[11:10]`, `[9:8]`).
- `id_uses_rs`, `id_uses_rt`  in  1 each  decoded: the ID instruction reads that source.
- `id_reg_write`  in  1  decoded RegWrite of the ID instruction.
- `id_write_reg`  in  2  destination of the ID instruction (already RegDst-muxed).
- `mem_pcsrc`  in  1  branch taken, from the EX/MEM stage (`PCsrc`).
- `pc_write`  out  1  PC load enable.
- `ifid_write`  out  1  IF/ID load enable.
- `idex_bubble`  out  1  load zero control bits into ID/EX at this edge.
- `flush_ifid`, `flush_idex`, `flush_exmem`  out  1 each  zero the instruction/control bits loaded into that register at this edge.
- `state`  out  2  FSM state, for debug.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters.

## Operation
- Scoreboard entries `sb[EX]`, `sb[MEM]`, `sb[WB]`, each holding {valid, reg[1:0]}.
- At every negedge, the scoreboard shifts one place: `sb[WB]`←`sb[MEM]`, `sb[MEM]`←`sb[EX]`.
  - `sb[EX]`←{`id_reg_write`, `id_write_reg`} when ID advances.
  - `sb[EX]`←{0,0} when stalling or flushing.
- A hazard exists when all of the following hold:
  - `hz_en` is 1.
  - Some valid entry has reg == `id_rs` with `id_uses_rs`, or reg == `id_rt` with `id_uses_rt`.
  - No stall exemption applies. The register file does not write-forward, so the WB entry counts as a hazard.
- Register 0 is an ordinary register; there is no r0 exemption.
- `stall` = hazard & !`mem_pcsrc`.
  - Outputs: `pc_write` = `ifid_write` = !`stall`; `idex_bubble` = `stall`.
- `flush` = `mem_pcsrc`.
  - Outputs: `flush_ifid` = `flush_idex` = `flush_exmem` = `flush`.
  - Clears the `sb[EX]` entry as it moves into `sb[MEM]`, because that instruction is younger than the branch.
  - `pc_write` = 1 so the target loads.
- Flush has priority over stall in the same cycle.
- FSM `hz_state_t` states:
  - RUN: no stall and no flush this cycle.
  - STALL: `stall` asserted.
  - FLUSH: `flush` asserted.
- FSM transitions are evaluated each negedge from the current cycle's decisions; `state` reflects the last completed cycle.
- Counters:
  - `stall_cnt` increments by 1 per stalled cycle.
  - `flush_cnt` increments by 1 per flush cycle.
  - Both saturate at 2^CNT_W−1 with no wrap.

## Timing
- Combinational outputs: `pc_write`, `ifid_write`, `idex_bubble`, `flush_*`.
  - Valid within the same cycle as their inputs.
  - They have no registered latency.
- A stall lasts at most 3 consecutive cycles per hazard: the producer drains EX→MEM→WB, after which ID proceeds.
- Producer in `sb[MEM]` → 2 stall cycles; producer in `sb[WB]` → 1 stall cycle.
- When a taken branch arrives during a stall, the stall ends that cycle, and ID is flushed instead.
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - Scoreboard all invalid; `state` = RUN; counters = 0.
  - Outputs: `pc_write` = `ifid_write` = 1; `idex_bubble` = 0; flushes = 0 (given `mem_pcsrc` = 0).
- Deassertion is sampled at the next negedge.

## Structure
- Shared package `cpu_pkg` holds:
  - `hz_state_t` (RUN=0, STALL=1, FLUSH=2).
  - `REG_W` = 2 and `DATA_W` = 16.
  - `sb_entry_t` {valid, reg}.
  - Stage index constants EX/MEM/WB.
- One sub-module, `sat_counter` (parameter width, inc, resetn), instantiated twice.
- The scoreboard and FSM live in the top module.

## Test plan
- ADD writing r1 in ID, next instruction reads r1 as rs → `stall` = 1 for 3 cycles.
  - `stall_cnt` = 3; `idex_bubble` pulses 3; ID proceeds on the 4th cycle.
- Producer r2 already in `sb[MEM]` when consumer reads r2 as rt → exactly 2 stall cycles.
- Consumer with `id_uses_rs` = 0 but rs == pending dest → no stall; `stall_cnt` unchanged.
- `mem_pcsrc` = 1 while a hazard on r3 is pending:
  - Required: `flush_*` = 1, `stall` = 0, `pc_write` = 1; `sb[EX]` cleared; `flush_cnt` = 1; `state` → FLUSH then RUN.
- `hz_en` = 0 with a back-to-back dependence on r0 → no stall.
  - Re-enable with a dependent pair → stall resumes.
- `resetn` low mid-stall (cycle 2 of 3):
  - Immediately `pc_write` = 1, counters = 0, `state` = RUN.
  - After release, with a valid consumer in ID, no stall, since the scoreboard is empty.
- Counter saturation, with `CNT_W` = 4: 20 stall cycles → `stall_cnt` holds 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit 5-stage CPU and its hazard sequencer.
package cpu_pkg;

    localparam int unsigned REG_W  = 2;
    localparam int unsigned DATA_W = 16;

    // Scoreboard stage indices, youngest first
    localparam int unsigned EX  = 0;
    localparam int unsigned MEM = 1;
    localparam int unsigned WB  = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] regnum;
    } sb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter clocked on the falling edge to match the CPU pipeline.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(negedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW-hazard stall and taken-branch flush sequencer for the 5-stage pipeline,
// with a 3-entry destination scoreboard and saturating event counters.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             hz_en,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic [REG_W-1:0] id_write_reg,
    input  logic             mem_pcsrc,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_entry_t sb [SB_DEPTH];
    hz_state_t state_q;
    hz_state_t state_d;
    logic      hazard;
    logic      stall;
    logic      flush;

    // Any in-flight writer (including WB, since the regfile does not forward) blocks ID
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (sb[i].valid &&
                ((id_uses_rs && (sb[i].regnum == id_rs)) ||
                 (id_uses_rt && (sb[i].regnum == id_rt)))) begin
                hazard = 1'b1;
            end
        end
        if (!hz_en) begin
            hazard = 1'b0;
        end
    end

    // Flush wins over stall; outputs are combinational for same-cycle pipeline control
    always_comb begin
        flush       = mem_pcsrc;
        stall       = hazard && !mem_pcsrc;
        state_d     = RUN;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (flush) begin
            state_d     = FLUSH;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if (stall) begin
            state_d     = STALL;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(negedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // The EX-stage instruction is younger than a taken branch, so it dies on the way to MEM
    always_ff @(negedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < SB_DEPTH; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[WB]  <= sb[MEM];
            sb[MEM] <= flush ? sb_entry_t'('0) : sb[EX];
            if (stall || flush) begin
                sb[EX] <= '0;
            end else begin
                sb[EX] <= '{valid: id_reg_write, regnum: id_write_reg};
            end
        end
    end

    assign state = state_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (stall),
        .count  (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (flush),
        .count  (flush_cnt)
    );

endmodule
